sub_bytes_iter: RTL

//   Iterative forward AES SubBytes engine for the encryption datapath. It is the

---
 rtl/sub_bytes_iter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sub_bytes_iter.sv
// ----------------------------------------------------------------------------
// sub_bytes_iter
//   Iterative forward AES SubBytes engine. It accepts one 128-bit state on the
//   input valid/ready handshake. It then substitutes LANES bytes per cycle
//   through LANES shared S-boxes, so a block takes N = 16/LANES cycles. The
//   result is presented on the output valid/ready handshake.
//
//   Ports
//     clk       rising-edge clock
//     rst_n     synchronous active-low reset
//     bytesIn   input state, byte 0 = [127:120] ... byte 15 = [7:0]
//     inValid   bytesIn valid
//     inReady   engine can accept bytesIn this cycle
//     bytesOut  substituted state (same byte order), qualified by outValid
//     outValid  bytesOut valid
//     outReady  downstream accepts bytesOut this cycle
//     busy      substitution in progress
//
// sub_bytes_sbox
//   Combinational forward AES S-box, in_i -> out_o.
// ----------------------------------------------------------------------------

module sub_bytes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);
  // Row-major S-box table. The concatenation puts entry 0x00 in the MSB
  // slot (index 255), so the lookup index is the bitwise inverse of the input.
  localparam logic [255:0][7:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_o = TBL[~in_i];
endmodule

module sub_bytes_iter #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] bytesIn,
  input  logic         inValid,
  output logic         inReady,
  output logic [127:0] bytesOut,
  output logic         outValid,
  input  logic         outReady,
  output logic         busy
);
  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [15:0][7:0]      work_q, work_d;   // element 15 holds byte 0
  logic [LANES-1:0][7:0] lane_in, lane_out;
  logic [LANES-1:0][3:0] lane_idx;

  // Group mux: lane l works on byte cnt*LANES+l. That byte sits in element
  // 15-(cnt*LANES+l) because byte 0 is the most significant.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_idx[l] = 4'(15 - (int'(cnt_q) * LANES + l));
    assign lane_in[l]  = work_q[lane_idx[l]];
    sub_bytes_sbox u_sbox (
      .in_i  (lane_in[l]),
      .out_o (lane_out[l])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    inReady  = 1'b0;
    outValid = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      IDLE: begin
        inReady = 1'b1;
        if (inValid) begin
          work_d  = bytesIn;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        for (int l = 0; l < LANES; l++) work_d[lane_idx[l]] = lane_out[l];
        if (cnt_q == CW'(N - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        outValid = 1'b1;
        // A draining result frees the engine in the same cycle, so a waiting
        // source is taken without a bubble.
        inReady  = outReady;
        if (outReady) begin
          if (inValid) begin
            work_d  = bytesIn;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bytesOut = work_q;
endmodule
